// File: rtl/rv_seq_sink.sv
// rv_seq_sink: valid/ready sink with programmable stall pattern and increment-sequence checker.
// Define RV_SINK_PROTO_CHK_EN to add the sticky proto_err upstream protocol monitor.
module rv_seq_sink #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [3:0]        stall_cycles,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              seq_err,
`ifdef RV_SINK_PROTO_CHK_EN
    output logic              proto_err,
`endif
    output logic [DATA_W-1:0] last_data
);
    typedef enum logic [1:0] {IDLE, ACCEPT, STALL} state_e;
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q;
    logic [CNT_W-1:0]  beat_q, beat_d, err_q, err_d;
    logic              seq_q, seq_d, sync_q, sync_d;
    logic [DATA_W-1:0] exp_q, exp_d, last_q, last_d;
    logic              hs;
    assign hs = valid & ready_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE:   state_d = ACCEPT;
                ACCEPT: if (hs && stall_cycles != 4'd0) begin
                    state_d = STALL;
                    cnt_d   = stall_cycles;
                end
                STALL: begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd1) ? ACCEPT : STALL;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // A clr beat still updates last_data, but is neither counted nor checked.
    always_comb begin
        beat_d = beat_q;
        err_d  = err_q;
        seq_d  = seq_q;
        sync_d = sync_q;
        exp_d  = exp_q;
        last_d = last_q;
        if (hs) begin
            last_d = data;
            exp_d  = data + DATA_W'(1);
            sync_d = 1'b1;
            beat_d = (&beat_q) ? beat_q : beat_q + CNT_W'(1);
            if (sync_q && data != exp_q) begin
                err_d = (&err_q) ? err_q : err_q + CNT_W'(1);
                seq_d = 1'b1;
            end
        end
        if (clr) begin
            beat_d = '0;
            err_d  = '0;
            seq_d  = 1'b0;
            sync_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            beat_q  <= '0;
            err_q   <= '0;
            seq_q   <= 1'b0;
            sync_q  <= 1'b0;
            exp_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ACCEPT);
            beat_q  <= beat_d;
            err_q   <= err_d;
            seq_q   <= seq_d;
            sync_q  <= sync_d;
            exp_q   <= exp_d;
            last_q  <= last_d;
        end
    end
    assign ready     = ready_q;
    assign beat_cnt  = beat_q;
    assign err_cnt   = err_q;
    assign seq_err   = seq_q;
    assign last_data = last_q;
`ifdef RV_SINK_PROTO_CHK_EN
    // pend_q: a beat was offered last cycle and not taken, so it must stay put.
    logic              pend_q, proto_q, proto_d;
    logic [DATA_W-1:0] pdata_q;
    assign proto_d = clr ? 1'b0 : (proto_q | (pend_q & (~valid | (data != pdata_q))));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            pdata_q <= '0;
            proto_q <= 1'b0;
        end else begin
            pend_q  <= valid & ~ready_q;
            pdata_q <= data;
            proto_q <= proto_d;
        end
    end
    assign proto_err = proto_q;
`endif
endmodule

// File: doc/rv_seq_sink.md
# rv_seq_sink

Downstream consumer for the 8-bit valid/ready stream produced by the incrementing-data sender. It generates `ready` with a programmable stall pattern to exercise back-pressure, and checks that accepted data forms a contiguous modulo-2^DATA_W increment sequence. It also exposes beat and error counters for the top level or a bench to read. It replaces the free-toggling receiver wherever deterministic back-pressure and in-line checking are required.

## Interface
- `DATA_W`, 8: stream data width.
- `CNT_W`, 16: width of beat and error counters.

- `clk`  in  1  clock, all state on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  sink enable; low forces IDLE, `ready`=0.
- `clr`  in  1  synchronous clear of counters, `seq_err` and sync state.
- `stall_cycles`  in  4  cycles of `ready`=0 inserted after each accepted beat (0 = none).
- `valid`  in  1  upstream data valid.
- `data`  in  DATA_W  upstream data.
- `ready`  out  1  registered ready to upstream.
- `beat_cnt`  out  CNT_W  accepted beats, saturating.
- `err_cnt`  out  CNT_W  sequence mismatches, saturating.
- `seq_err`  out  1  sticky: at least one mismatch since reset/clr.
- `last_data`  out  DATA_W  data of most recent accepted beat.
- `proto_err`  out  1  sticky protocol violation; present only with `RV_SINK_PROTO_CHK_EN`.

## Operation
- Reset values: `ready`=0, `beat_cnt`=0, `err_cnt`=0, `seq_err`=0, `last_data`=0, `proto_err`=0. State is IDLE, the stall counter is 0, `in_sync`=0 and `expected`=0.
- A handshake occurs on a posedge where `valid && ready`. It is the only event that consumes data.
- FSM states:
  - IDLE: `ready`=0. If `en`=1, go to ACCEPT.
  - ACCEPT: `ready`=1.
    - On a handshake with `stall_cycles`=0, stay in ACCEPT.
    - On a handshake with `stall_cycles`=N>0, load the stall counter with N and go to STALL.
  - STALL: `ready`=0. The counter decrements each cycle. When the counter equals 1, go to ACCEPT.
  - Any state: if `en`=0, go to IDLE. `en` has priority over all other transitions.
- `stall_cycles` is sampled only at the handshake. Changing it mid-STALL has no effect on the current stall.
- Checker, evaluated on each handshake:
  - If `in_sync`=0: no compare. Set `in_sync`=1.
  - If `in_sync`=1 and `data`≠`expected`: increment `err_cnt` and set `seq_err`=1.
  - In both cases, set `expected`=`data`+1 mod 2^DATA_W, increment `beat_cnt`, and set `last_data`=`data`.
- Wrap: `expected` after 0xFF is 0x00, and this is not an error.
- Counters saturate at all-ones. They do not wrap.
- `clr`=1 sets `beat_cnt`, `err_cnt`, `seq_err` and `in_sync` to 0.
  - A handshake in the same cycle is still accepted. `ready` and the FSM are unaffected, and `last_data` updates.
  - That beat is not counted or checked. The next beat resynchronises.
- `en` does not touch `in_sync`. Re-enabling continues checking against `expected`.
- `rst` asserted mid-stall or mid-transfer returns every output to its reset value immediately. A beat in flight is dropped.

## Timing
- `ready` is a flop output with no combinational path from `valid` or `data`.
- `en` rising at posedge k gives `ready`=1 from posedge k+1.
- Handshake at posedge k with N>0 gives `ready`=0 for exactly N cycles (k+1 … k+N) and `ready`=1 again from k+N+1.
- With N=0 and `valid` held high, there is one beat per cycle.
- `beat_cnt`, `err_cnt`, `seq_err` and `last_data` are visible the cycle after the handshake (1-cycle latency).
- `en` falling at posedge k gives `ready`=0 from k+1. Any handshake at k itself still completes.

## Configuration
- `RV_SINK_PROTO_CHK_EN` defined: `proto_err` is set sticky (cleared only by `rst` or `clr`) when either of these holds:
  - `valid` falls while `ready`=0 and no handshake has occurred since `valid` rose.
  - `data` changes while `valid`=1 and `ready`=0.
- Comparisons use registered copies of the previous cycle's `valid` and `data`.
- `RV_SINK_PROTO_CHK_EN` undefined: the port `proto_err` and its logic are absent, and the block behaves identically otherwise.

## Test plan
- Reset, then `en`=1, `stall_cycles`=0, incrementing source from 0x00, 300 beats → `ready` constant 1, `beat_cnt`=300, `err_cnt`=0, data wraps 0xFF→0x00 with no error, `last_data`=0x2B.
- `stall_cycles`=3, `valid` held high → `ready` pattern 1,0,0,0 repeating; 10 beats in 40 cycles after the first `ready`.
- Source skips one value (…0x05, 0x07, 0x08…) → `err_cnt`=1, `seq_err`=1 the cycle after 0x07 is accepted; 0x08 is not flagged.
- `clr` pulsed on the same cycle as the handshake of 0x10, then next beat 0x40 → `beat_cnt`=1, `err_cnt`=0, `seq_err`=0; the 0x40 beat resyncs and 0x41 checks clean.
- `rst` asserted during STALL with `stall_cycles`=5 → `ready`=0 and all counters 0 immediately; after release with `en`=1, `ready`=1 the cycle after `en` is sampled.
- With `RV_SINK_PROTO_CHK_EN`: change `data` 0x20→0x21 while `valid`=1 and `ready`=0 → `proto_err`=1 next cycle and stays 1 until `clr`.
